dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Shares the single-port data memory between two requesters.
  - Port 0: CPU control unit, used for LD/ST.
  - Port 1: program loader/debug master.
- Sits between the requesters and the data memory.
- At most one access is accepted per cycle.
- Arbitration is round-robin with a bounded hold, so a streaming loader cannot starve the CPU.
- Read data is returned in order, tagged to the requester that issued the read.

Parameters:
DATA_W, 19, data word width (CPU word size)
ADDR_W, 19, data memory address width
RD_LAT, 1, memory read latency in cycles from accepted read to MEM_RDATA valid; legal 1..4
MAX_HOLD, 4, max consecutive accepted accesses by the current owner while the other port is requesting; legal 1..15

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
REQ_0  in  1  port 0 access request
WE_0  in  1  port 0 write (1) / read (0)
ADDR_0  in  ADDR_W  port 0 address
WDATA_0  in  DATA_W  port 0 write data
GNT_0  out  1  port 0 access accepted this cycle
RVALID_0  out  1  port 0 read data valid
RDATA_0  out  DATA_W  port 0 read data
REQ_1, WE_1, ADDR_1, WDATA_1, GNT_1, RVALID_1, RDATA_1: same as port 0, for port 1
MEM_EN  out  1  memory access strobe
MEM_WE  out  1  memory write enable
MEM_ADDR  out  ADDR_W  memory address
MEM_WDATA  out  DATA_W  memory write data
MEM_RDATA  in  DATA_W  memory read data, valid RD_LAT cycles after a read strobe

Behaviour:
- Reset (RST_N low, asynchronous):
  - State IDLE, hold count 0, last_served = 1 (so port 0 wins the first tie).
  - Tag pipeline cleared.
  - GNT_0/1, RVALID_0/1 and MEM_EN forced to 0; RDATA_0/1 = 0.
- Handshake:
  - A request is held with its controls stable until GNT_i = 1.
  - An access is accepted in the cycle REQ_i && GNT_i.
  - GNT_i is combinational from REQ and the registered arbitration state, with zero added latency.
  - GNT_i never asserts without REQ_i. GNT_0 and GNT_1 are never both 1.
- States: IDLE, OWN0, OWN1 (owner = port granted in the previous cycle).
  - IDLE:
    - Single requester wins.
    - Both requesting: the port != last_served wins.
    - Next state is OWNi of the winner; stays IDLE if no request.
  - OWNi, other port not requesting: owner keeps the grant if requesting, with no hold limit.
  - OWNi, both requesting:
    - Owner keeps the grant while hold < MAX_HOLD.
    - When hold = MAX_HOLD, the other port wins.
  - OWNi, owner drops REQ: the other port wins immediately if requesting; otherwise go to IDLE.
  - On every owner change: hold resets to 1 (the winner's first access) and last_served = new owner.
  - Same owner is granted again: hold increments, saturating at MAX_HOLD.
- Memory side (combinational from the winner):
  - MEM_EN = GNT_0 | GNT_1.
  - MEM_WE/ADDR/WDATA are muxed from the winning port.
  - When MEM_EN = 0, MEM_WE = 0 and MEM_ADDR/MEM_WDATA = 0.
- Writes: complete at acceptance; no response.
- Reads:
  - An accepted read pushes {valid, port id} into an RD_LAT-deep shift pipeline.
  - At the pipeline output, RVALID_id = 1 for one cycle, RDATA_id = MEM_RDATA, and the other port's RDATA = 0.
  - Throughput is one read per cycle; responses are strictly in acceptance order.
- Write then read to the same address in consecutive cycles returns the new data, provided memory is write-first. The arbiter adds no reordering.
- Reset mid-operation: in-flight reads are discarded; no RVALID pulses after RST_N rises for reads issued before reset.

Decomposition:
- Package dm_arb_pkg:
  - arb_state_t enum {IDLE, OWN0, OWN1}.
  - port_id_t (1 bit).
  - Constants PORT_CPU = 0 and PORT_LDR = 1.
- Sub-module rd_tag_pipe:
  - Parameterised RD_LAT-stage shift register of {valid, port_id_t}.
  - Uses the same CLK/RST_N.
  - Outputs the tag at the tail.

Test Plan:
- Port 0 read of ADDR 0x00010, RD_LAT=1, memory returns 0x1ABCD -> GNT_0 same cycle, RVALID_0 next cycle with RDATA_0 = 0x1ABCD, RVALID_1 stays 0.
- Both ports request in the first cycle after reset -> port 0 granted first, then port 1 on the next cycle if port 0 drops REQ.
- Both ports hold REQ continuously, MAX_HOLD=4 -> grant pattern 0,0,0,0,1,1,1,1,0,... and never both GNT high.
- Port 1 writes 0x07FFF to ADDR 5, then port 0 reads ADDR 5 -> MEM_WE pulse with port 1 data, then RDATA_0 = 0x07FFF.
- RD_LAT=3, port 0 issues reads A, B, C back-to-back -> RVALID_0 high for 3 consecutive cycles starting 3 cycles after A, with data in order A, B, C.
- Read accepted, RST_N pulsed low before its response -> no RVALID on either port; all outputs 0 during reset; arbitration restarts with port 0 priority.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared types and constants for the data-memory arbiter.
//   arb_state_t : arbitration FSM state (IDLE, OWN0, OWN1)
//   port_id_t   : requester identifier (1 bit)
//   rd_tag_t    : {valid, port id} tag carried alongside an outstanding read
//   PORT_CPU/PORT_LDR : port id constants
//   HOLD_W      : width of the hold counter (MAX_HOLD up to 15)
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef logic port_id_t;

    localparam port_id_t PORT_CPU = 1'b0;
    localparam port_id_t PORT_LDR = 1'b1;

    localparam int HOLD_W = 4;

    typedef struct packed {
        logic     valid;
        port_id_t id;
    } rd_tag_t;

    function automatic port_id_t other_port(input port_id_t p);
        return ~p;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: RD_LAT-stage shift register of read tags. A tag pushed in the
// cycle a read is accepted appears at the tail exactly RD_LAT cycles later,
// lined up with the memory's read data.
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset (clears all stages)
//   push_tag   : tag entering stage 0 this cycle (valid=0 when no read)
//   tail_tag   : tag leaving the last stage
module rd_tag_pipe
    import dm_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    CLK,
    input  logic    RST_N,
    input  rd_tag_t push_tag,
    output rd_tag_t tail_tag
);

    rd_tag_t [RD_LAT-1:0] stage_q;
    rd_tag_t [RD_LAT-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = push_tag;
        for (int i = 1; i < RD_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Clearing on reset is what discards in-flight reads.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tail_tag = stage_q[RD_LAT-1];

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares a single-port data memory between the CPU (port 0) and
// the program loader / debug master (port 1).
//
// Handshake: a requester raises REQ_i with WE_i/ADDR_i/WDATA_i and holds them
// stable until GNT_i; the access is accepted in the cycle REQ_i && GNT_i.
// GNT_i is combinational from REQ and the registered arbitration state. Reads
// return RVALID_i/RDATA_i exactly RD_LAT cycles after acceptance, in order.
//
// Ports:
//   CLK, RST_N                      : clock, asynchronous active-low reset
//   REQ_i, WE_i, ADDR_i, WDATA_i    : requester i access (i = 0 CPU, 1 loader)
//   GNT_i                           : access of port i accepted this cycle
//   RVALID_i, RDATA_i               : read response for port i
//   MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA : memory strobe/controls (zero when idle)
//   MEM_RDATA                       : memory read data, RD_LAT cycles after strobe
//   dbg_state                       : current arbitration state
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DATA_W   = 19,
    parameter int ADDR_W   = 19,
    parameter int RD_LAT   = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ_0,
    input  logic              WE_0,
    input  logic [ADDR_W-1:0] ADDR_0,
    input  logic [DATA_W-1:0] WDATA_0,
    output logic              GNT_0,
    output logic              RVALID_0,
    output logic [DATA_W-1:0] RDATA_0,
    input  logic              REQ_1,
    input  logic              WE_1,
    input  logic [ADDR_W-1:0] ADDR_1,
    input  logic [DATA_W-1:0] WDATA_1,
    output logic              GNT_1,
    output logic              RVALID_1,
    output logic [DATA_W-1:0] RDATA_1,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output arb_state_t        dbg_state
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    arb_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    port_id_t          last_q, last_d;

    logic     gnt_any;
    port_id_t win;
    port_id_t owner;
    logic     owner_req;
    logic     other_req;

    rd_tag_t  push_tag;
    rd_tag_t  tail_tag;

    // Winner selection and next-state.
    always_comb begin
        gnt_any   = 1'b0;
        win       = PORT_CPU;
        owner     = (state_q == OWN1) ? PORT_LDR : PORT_CPU;
        owner_req = (owner == PORT_LDR) ? REQ_1 : REQ_0;
        other_req = (owner == PORT_LDR) ? REQ_0 : REQ_1;

        case (state_q)
            OWN0, OWN1: begin
                // Owner keeps the grant unless the other port is waiting and
                // the owner has used up its hold budget.
                if (owner_req && (!other_req || (hold_q < MAX_HOLD_C))) begin
                    gnt_any = 1'b1;
                    win     = owner;
                end else if (other_req) begin
                    gnt_any = 1'b1;
                    win     = other_port(owner);
                end
            end
            default: begin
                if (REQ_0 && REQ_1) begin
                    gnt_any = 1'b1;
                    win     = other_port(last_q);
                end else if (REQ_1) begin
                    gnt_any = 1'b1;
                    win     = PORT_LDR;
                end else if (REQ_0) begin
                    gnt_any = 1'b1;
                    win     = PORT_CPU;
                end
            end
        endcase

        // Nothing is accepted while reset is held.
        if (!RST_N) begin
            gnt_any = 1'b0;
        end

        state_d = state_q;
        hold_d  = hold_q;
        last_d  = last_q;
        if (gnt_any) begin
            state_d = (win == PORT_LDR) ? OWN1 : OWN0;
            last_d  = win;
            if (state_q == state_d) begin
                hold_d = (hold_q == MAX_HOLD_C) ? hold_q : hold_q + 1'b1;
            end else begin
                hold_d = HOLD_W'(1);
            end
        end else begin
            state_d = IDLE;
            hold_d  = '0;
        end
    end

    // last_q resets to the loader so the CPU wins the first tie.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            hold_q  <= '0;
            last_q  <= PORT_LDR;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    assign GNT_0 = gnt_any && (win == PORT_CPU);
    assign GNT_1 = gnt_any && (win == PORT_LDR);

    // Memory side: muxed from the winner, all zero when nothing is accepted.
    always_comb begin
        MEM_EN    = gnt_any;
        MEM_WE    = 1'b0;
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        if (GNT_0) begin
            MEM_WE    = WE_0;
            MEM_ADDR  = ADDR_0;
            MEM_WDATA = WDATA_0;
        end else if (GNT_1) begin
            MEM_WE    = WE_1;
            MEM_ADDR  = ADDR_1;
            MEM_WDATA = WDATA_1;
        end
    end

    assign push_tag.valid = gnt_any && !MEM_WE;
    assign push_tag.id    = win;

    rd_tag_pipe #(
        .RD_LAT(RD_LAT)
    ) u_rd_tag_pipe (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .push_tag (push_tag),
        .tail_tag (tail_tag)
    );

    assign RVALID_0 = tail_tag.valid && (tail_tag.id == PORT_CPU);
    assign RVALID_1 = tail_tag.valid && (tail_tag.id == PORT_LDR);
    assign RDATA_0  = RVALID_0 ? MEM_RDATA : '0;
    assign RDATA_1  = RVALID_1 ? MEM_RDATA : '0;

    assign dbg_state = state_q;

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  localparam int DW       = 19;
  localparam int AW       = 19;
  localparam int MAX_HOLD = 4;
  localparam int NI       = 2;
  localparam int EW       = 16 + 1 + DW;

  // ---------------- clock / reset ----------------
  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- shared stimulus ----------------
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wd0 = '0, wd1 = '0;

  logic [NI-1:0] gnt0_w, gnt1_w;
  logic          g0_s = 1'b0, g1_s = 1'b0;
  always @(negedge CLK) begin
    g0_s <= gnt0_w[0];
    g1_s <= gnt1_w[0];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 16) return 19'h1ABCD;
    return DW'(32'h2B5A3 + i * 32'h1F31);
  endfunction

  // ---------------- DUT instances (RD_LAT = 1 and 3), memory + scoreboard ----------------
  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;

    logic          rv0, rv1, men, mwe;
    logic [DW-1:0] rd0, rd1, mwd, mrd;
    logic [AW-1:0] ma;
    arb_state_t    dbg;

    dm_arbiter #(
      .DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT), .MAX_HOLD(MAX_HOLD)
    ) dut (
      .CLK(CLK), .RST_N(RST_N),
      .REQ_0(req0), .WE_0(we0), .ADDR_0(addr0), .WDATA_0(wd0),
      .GNT_0(gnt0_w[g]), .RVALID_0(rv0), .RDATA_0(rd0),
      .REQ_1(req1), .WE_1(we1), .ADDR_1(addr1), .WDATA_1(wd1),
      .GNT_1(gnt1_w[g]), .RVALID_1(rv1), .RDATA_1(rd1),
      .MEM_EN(men), .MEM_WE(mwe), .MEM_ADDR(ma), .MEM_WDATA(mwd),
      .MEM_RDATA(mrd), .dbg_state(dbg)
    );

    // Write-first memory with LAT-cycle read latency, driven by the DUT.
    logic [DW-1:0] mem  [32];
    logic [DW-1:0] gold [32];
    logic [DW-1:0] dl   [LAT];
    logic          en_p = 1'b0, we_p = 1'b0;
    logic [4:0]    a_p = '0;
    logic [DW-1:0] wd_p = '0;

    initial begin
      for (int i = 0; i < 32; i++) begin
        mem[i]  = init_val(i);
        gold[i] = init_val(i);
      end
      for (int i = 0; i < LAT; i++) dl[i] = '0;
    end

    assign mrd = dl[LAT-1];

    always @(negedge CLK) begin
      en_p = men;
      we_p = mwe;
      a_p  = ma[4:0];
      wd_p = mwd;
    end

    always @(posedge CLK) begin
      for (int i = LAT - 1; i > 0; i--) dl[i] = dl[i-1];
      dl[0] = (en_p && !we_p) ? mem[a_p] : '0;
      if (en_p && we_p) mem[a_p] = wd_p;
    end

    // Reference model: owner = port granted last cycle (-1 none), run =
    // consecutive grants to it (saturating), last = most recently served.
    int               own  = -1;
    int               run  = 0;
    int               last = 1;
    int               win;
    logic [EW-1:0]    exp_q[$];
    logic [EW-1:0]    e;
    logic             ewe;
    logic [AW-1:0]    eaddr;
    logic [DW-1:0]    ewd;
    arb_state_t       est;

    always @(negedge CLK) begin
      if (!RST_N) begin
        chk($sformatf("L%0d rst_gnt", LAT), {gnt0_w[g], gnt1_w[g]}, 0);
        chk($sformatf("L%0d rst_rvalid", LAT), {rv0, rv1}, 0);
        chk($sformatf("L%0d rst_mem_en", LAT), men, 0);
        chk($sformatf("L%0d rst_rdata", LAT), {rd0, rd1}, 0);
        chk($sformatf("L%0d rst_state", LAT), dbg, IDLE);
        own  = -1;
        run  = 0;
        last = 1;
        exp_q.delete();
      end else begin
        // ---- read responses ----
        chk($sformatf("L%0d rvalid_both", LAT), rv0 & rv1, 0);
        if (rv0 || rv1) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("L%0d rvalid_unexpected", LAT), 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("L%0d rd_cycle", LAT), e[EW-1:DW+1], 16'(cyc));
            chk($sformatf("L%0d rd_port", LAT), rv1, e[DW]);
            chk($sformatf("L%0d rd_data", LAT), rv1 ? rd1 : rd0, e[DW-1:0]);
            chk($sformatf("L%0d rd_other_zero", LAT), rv1 ? rd0 : rd1, 0);
          end
        end else if (exp_q.size() > 0 && exp_q[0][EW-1:DW+1] <= 16'(cyc)) begin
          e = exp_q.pop_front();
          chk($sformatf("L%0d rvalid_missing", LAT), 0, 1);
        end

        // ---- arbitration ----
        est = (own < 0) ? IDLE : ((own == 1) ? OWN1 : OWN0);
        chk($sformatf("L%0d state", LAT), dbg, est);
        win = -1;
        if (req0 && req1) win = (own >= 0 && run < MAX_HOLD) ? own : 1 - last;
        else if (req0) win = 0;
        else if (req1) win = 1;

        ewe   = (win == 0) ? we0 : (win == 1) ? we1 : 1'b0;
        eaddr = (win == 0) ? addr0 : (win == 1) ? addr1 : '0;
        ewd   = (win == 0) ? wd0 : (win == 1) ? wd1 : '0;
        chk($sformatf("L%0d gnt0", LAT), gnt0_w[g], win == 0);
        chk($sformatf("L%0d gnt1", LAT), gnt1_w[g], win == 1);
        chk($sformatf("L%0d mem_en", LAT), men, win >= 0);
        chk($sformatf("L%0d mem_we", LAT), mwe, ewe);
        chk($sformatf("L%0d mem_addr", LAT), ma, eaddr);
        chk($sformatf("L%0d mem_wdata", LAT), mwd, ewd);

        if (win >= 0) begin
          if (win == own) run = (run < MAX_HOLD) ? run + 1 : MAX_HOLD;
          else run = 1;
          own  = win;
          last = win;
          if (ewe) gold[eaddr[4:0]] = ewd;
          else exp_q.push_back({16'(cyc + LAT), 1'(win), gold[eaddr[4:0]]});
        end else begin
          own = -1;
          run = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set0(input logic r, input logic w, input int a, input logic [DW-1:0] d);
    req0 = r; we0 = w; addr0 = AW'(a); wd0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input int a, input logic [DW-1:0] d);
    req1 = r; we1 = w; addr1 = AW'(a); wd1 = d;
  endtask

  // A port with an outstanding request keeps it until granted.
  task automatic rand_cycle(input int p);
    if (!req0 || g0_s)
      set0($urandom_range(0, 99) < p, $urandom_range(0, 2) == 0, $urandom_range(0, 31), DW'($urandom));
    if (!req1 || g1_s)
      set1($urandom_range(0, 99) < p, $urandom_range(0, 2) == 0, $urandom_range(0, 31), DW'($urandom));
    tick();
  endtask

  int exp_pat[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

  // ---------------- main sequence ----------------
  initial begin
    // Requests raised during reset must not be granted.
    set0(1, 0, 0, '0);
    set1(1, 0, 1, '0);
    repeat (3) tick();
    RST_N = 1'b1;                         // both requesting in the first cycle
    tick();                               // port 0 won the tie
    set0(0, 0, 0, '0);
    tick();                               // port 1 now granted
    set1(0, 0, 0, '0);
    tick();

    // Port 0 read of 0x10 returns 0x1ABCD.
    set0(1, 0, 16, '0);
    tick();
    set0(0, 0, 0, '0);
    tick();

    // Loader write then CPU read of the same address.
    set1(1, 1, 5, 19'h07FFF);
    tick();
    set1(0, 0, 0, '0);
    set0(1, 0, 5, '0);
    tick();
    set0(0, 0, 0, '0);
    tick();

    // Back-to-back reads A, B, C.
    set0(1, 0, 1, '0); tick();
    set0(1, 0, 2, '0); tick();
    set0(1, 0, 3, '0); tick();
    set0(0, 0, 0, '0);
    repeat (5) tick();

    // Reset while a read is in flight.
    set0(1, 0, 7, '0);
    tick();
    set0(0, 0, 0, '0);
    RST_N = 1'b0;
    repeat (2) tick();
    set0(1, 0, 8, '0);
    set1(1, 0, 9, '0);
    RST_N = 1'b1;

    // Both requesting continuously: hold-limited alternation from fresh reset.
    for (int k = 0; k < 9; k++) begin
      @(negedge CLK);
      chk($sformatf("pattern_gnt1_%0d", k), gnt1_w[0], exp_pat[k]);
      chk($sformatf("pattern_gnt0_%0d", k), gnt0_w[0], exp_pat[k] == 0);
      tick();
    end
    set0(0, 0, 0, '0);
    set1(0, 0, 0, '0);
    repeat (5) tick();

    // Randomized traffic at several load levels.
    repeat (200) rand_cycle(90);
    repeat (200) rand_cycle(50);
    repeat (200) rand_cycle(20);
    set0(0, 0, 0, '0);
    set1(0, 0, 0, '0);
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
